// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the IF/EX/WB stall and flush sequencer.
// PIPE_PERF_CNT_EN enables the stall/flush performance counters.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } ctrl_state_e;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Instantiated by pipeline_hazard_ctrl when PIPE_PERF_CNT_EN is defined.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 3-stage pipeline with memory watchdog.
// Define PIPE_PERF_CNT_EN to build the stall_cycles/flush_count counters.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int unsigned CNT_W          = 5,
   parameter int unsigned PERF_W         = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ex_mem_req,
   input  logic              ex_mem_done,
   input  logic              ex_branch_taken,
   output logic              pc_en,
   output logic              if_ex_en,
   output logic              if_ex_flush,
   output logic              ex_wb_en,
   output logic              ex_wb_flush,
   output logic              mem_timeout,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_count
);

   ctrl_state_e      state_q;
   ctrl_state_e      state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_en       = 1'b0;
      if_ex_en    = 1'b0;
      ex_wb_en    = 1'b0;
      if_ex_flush = 1'b0;
      ex_wb_flush = 1'b0;
      mem_timeout = 1'b0;
      if (reset) begin
         if_ex_flush = 1'b1;
         ex_wb_flush = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               // A stall outranks a branch: EX is held so it re-presents.
               if (ex_mem_req && !ex_mem_done) begin
                  ex_wb_flush = 1'b1;
                  state_d     = MEM_WAIT;
                  cnt_d       = CNT_W'(1);
               end else begin
                  pc_en       = 1'b1;
                  if_ex_en    = 1'b1;
                  ex_wb_en    = 1'b1;
                  if_ex_flush = ex_branch_taken;
               end
            end
            MEM_WAIT: begin
               if (ex_mem_done) begin
                  pc_en       = 1'b1;
                  if_ex_en    = 1'b1;
                  ex_wb_en    = 1'b1;
                  if_ex_flush = ex_branch_taken;
                  state_d     = RUN;
                  cnt_d       = '0;
               end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                  ex_wb_flush = 1'b1;
                  state_d     = ERROR;
               end else begin
                  ex_wb_flush = 1'b1;
                  cnt_d       = cnt_q + CNT_W'(1);
               end
            end
            ERROR: begin
               if_ex_flush = 1'b1;
               ex_wb_flush = 1'b1;
               mem_timeout = 1'b1;
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (~pc_en),
      .count (stall_cycles)
   );

   sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (if_ex_flush),
      .count (flush_count)
   );
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios
// plus randomized traffic against a behavioural stall/flush model.
module tb_pipeline_hazard_ctrl;

   localparam int TMO = 16;
`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        ex_mem_req;
   logic        ex_mem_done;
   logic        ex_branch_taken;
   logic        pc_en;
   logic        if_ex_en;
   logic        if_ex_flush;
   logic        ex_wb_en;
   logic        ex_wb_flush;
   logic        mem_timeout;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   int tests;
   int failed;

   pipeline_hazard_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .ex_mem_req      (ex_mem_req),
      .ex_mem_done     (ex_mem_done),
      .ex_branch_taken (ex_branch_taken),
      .pc_en           (pc_en),
      .if_ex_en        (if_ex_en),
      .if_ex_flush     (if_ex_flush),
      .ex_wb_en        (ex_wb_en),
      .ex_wb_flush     (ex_wb_flush),
      .mem_timeout     (mem_timeout),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model state: sticky error flag and length of the current stall.
   bit      armed;
   bit      m_err;
   int      m_waited;
   longint  m_stall;
   longint  m_flush;

   // {pc_en, if_ex_en, ex_wb_en, if_ex_flush, ex_wb_flush, mem_timeout}
   function automatic logic [5:0] expect_ctl(bit rst, bit req, bit done,
                                             bit br, bit err, int waited);
      bit stalling;
      if (rst) return 6'b000110;
      if (err) return 6'b000111;
      stalling = (waited > 0) ? !done : (req && !done);
      if (stalling) return 6'b000010;
      return {3'b111, br, 2'b00};
   endfunction

   always @(posedge clock) begin
      logic [5:0] e;
      e = expect_ctl(reset, ex_mem_req, ex_mem_done, ex_branch_taken,
                     m_err, m_waited);
      if (reset) begin
         armed    <= 1'b1;
         m_err    = 1'b0;
         m_waited = 0;
         m_stall  = 0;
         m_flush  = 0;
      end else begin
         if (!e[5] && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (e[2] && m_flush < 64'hFFFF_FFFF) m_flush++;
         if (!m_err) begin
            if (e[5]) begin
               m_waited = 0;
            end else begin
               m_waited++;
               if (m_waited > TMO) m_err = 1'b1;
            end
         end
      end
   end

   always @(negedge clock) begin
      logic [5:0]  e;
      logic [5:0]  g;
      logic [31:0] es;
      logic [31:0] ef;
      if (armed) begin
         e  = expect_ctl(reset, ex_mem_req, ex_mem_done, ex_branch_taken,
                         m_err, m_waited);
         g  = {pc_en, if_ex_en, ex_wb_en, if_ex_flush, ex_wb_flush,
               mem_timeout};
         es = PERF ? 32'(m_stall) : 32'd0;
         ef = PERF ? 32'(m_flush) : 32'd0;
         tests++;
         if (g !== e) begin
            failed++;
            $display("FAIL ctl t=%0t got=%b exp=%b", $time, g, e);
         end
         tests++;
         if (stall_cycles !== es || flush_count !== ef) begin
            failed++;
            $display("FAIL perf t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                     stall_cycles, flush_count, es, ef);
         end
      end
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic drive(bit r, bit q, bit d, bit b);
      @(posedge clock);
      #1;
      reset           = r;
      ex_mem_req      = q;
      ex_mem_done     = d;
      ex_branch_taken = b;
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
   endtask

   function automatic logic [31:0] ctl6();
      return {26'd0, pc_en, if_ex_en, ex_wb_en, if_ex_flush, ex_wb_flush,
              mem_timeout};
   endfunction

   initial begin
      int thr;
      tests           = 0;
      failed          = 0;
      reset           = 1'b1;
      ex_mem_req      = 1'b0;
      ex_mem_done     = 1'b0;
      ex_branch_taken = 1'b0;

      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      chk("reset_ctl", ctl6(), 32'b000110);
      drive(0, 0, 0, 0);
      chk("post_reset_ctl", ctl6(), 32'b111000);

      drive(0, 1, 1, 0);
      chk("req_done_same_pc_en", 32'(pc_en), 32'd1);
      drive(0, 0, 0, 0);
      chk("req_done_same_stall", stall_cycles, 32'd0);

      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0);
         chk("stall3_ctl", ctl6(), 32'b000010);
      end
      drive(0, 1, 1, 0);
      chk("stall3_release", ctl6(), 32'b111000);
      drive(0, 0, 0, 0);
      chk("stall3_count", stall_cycles, PERF ? 32'd3 : 32'd0);

      do_reset();
      drive(0, 0, 0, 1);
      chk("branch_ctl", ctl6(), 32'b111100);
      drive(0, 0, 0, 0);
      chk("branch_after", 32'(if_ex_flush), 32'd0);
      chk("branch_flush_cnt", flush_count, PERF ? 32'd1 : 32'd0);

      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 1);
         chk("stall_br_noflush", ctl6(), 32'b000010);
      end
      drive(0, 1, 1, 1);
      chk("stall_br_release", ctl6(), 32'b111100);
      drive(0, 0, 0, 0);
      chk("stall_br_flush_cnt", flush_count, PERF ? 32'd1 : 32'd0);
      chk("stall_br_stall_cnt", stall_cycles, PERF ? 32'd2 : 32'd0);

      do_reset();
      for (int i = 0; i <= TMO; i++) begin
         drive(0, 1, 0, 0);
      end
      chk("tmo_last_wait", ctl6(), 32'b000010);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0);
         chk("tmo_sticky", ctl6(), 32'b000111);
      end
      drive(0, 0, 0, 0);
      chk("tmo_error_idle", 32'(mem_timeout), 32'd1);
      chk("tmo_stall_cnt", stall_cycles, PERF ? 32'd20 : 32'd0);
      drive(1, 0, 0, 0);
      chk("tmo_reset", 32'(mem_timeout), 32'd0);
      drive(0, 0, 0, 0);
      chk("tmo_recover", ctl6(), 32'b111000);

      for (int blk = 0; blk < 12; blk++) begin
         thr = (blk % 4 == 3) ? 0 : int'($urandom_range(2, 10));
         for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 127) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 15) < thr),
                  ($urandom_range(0, 3) == 0));
         end
         drive(1, 0, 0, 0);
      end

      drive(0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
